// File: rtl/spi_recv.sv
// SPI-slave receive path (mode 0): oversampled in axi_aclk, bytes deserialised MSB-first and
// delivered as an AXI4-Stream master through a {last,data} FIFO.
module spi_recv #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       axi_aclk,
   input  logic       axi_areset,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_cs,
   output logic [7:0] axis_wdata,
   output logic       axis_wvalid,
   input  logic       axis_wready,
   output logic       axis_wlast,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StActive, StEnd} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, cs_rise, cs_fall;

   state_e     state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q, hold_q, push_data_q;
   logic       hold_vld_q, push_q, push_last_q, frame_err_q;
   logic [7:0] new_byte;

   logic [8:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overflow_q, full, pop, accept;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign new_byte  = {shift_q[6:0], mosi_s};

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   // A completed byte waits in hold until we know whether it is the frame's last one.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         hold_q      <= 8'd0;
         hold_vld_q  <= 1'b0;
         push_q      <= 1'b0;
         push_last_q <= 1'b0;
         push_data_q <= 8'd0;
         frame_err_q <= 1'b0;
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cs_rise) begin
                  bit_cnt_q <= 3'd0;
                  shift_q   <= 8'd0;
                  state_q   <= StActive;
               end
            end
            StActive: begin
               if (cs_fall) begin
                  state_q <= StEnd;
               end else if (sclk_rise) begin
                  shift_q   <= new_byte;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (hold_vld_q) begin
                        push_q      <= 1'b1;
                        push_last_q <= 1'b0;
                        push_data_q <= hold_q;
                     end
                     hold_q     <= new_byte;
                     hold_vld_q <= 1'b1;
                  end
               end
            end
            StEnd: begin
               if (hold_vld_q) begin
                  push_q      <= 1'b1;
                  push_last_q <= 1'b1;
                  push_data_q <= hold_q;
                  hold_vld_q  <= 1'b0;
               end
               frame_err_q <= (bit_cnt_q != 3'd0);
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign full   = (32'(count_q) == FIFO_DEPTH);
   assign pop    = axis_wvalid & axis_wready;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign accept = push_q & (~full | pop);

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && !pop) count_q <= count_q + 1'b1;
         else if (!accept && pop) count_q <= count_q - 1'b1;
         if (push_q && !accept) overflow_q <= 1'b1;
      end
   end

   assign axis_wvalid = (count_q != '0);
   assign axis_wdata  = mem_q[rd_ptr_q][7:0];
   assign axis_wlast  = mem_q[rd_ptr_q][8];
   assign overflow    = overflow_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_recv.sv
// Randomised scoreboard bench for spi_recv: stimulus queues expected beats, a monitor pops them.
module tb_spi_recv;

   localparam int unsigned Depth = 16;

   logic       axi_aclk = 1'b0;
   logic       axi_areset = 1'b1;
   logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b0;
   logic [7:0] axis_wdata;
   logic       axis_wvalid, axis_wready, axis_wlast, overflow, frame_err;

   int         total = 0, bad = 0;
   logic [8:0] exp_q[$];
   logic [7:0] frame_q[$];
   logic       exp_ovf = 1'b0;
   int         fe_cnt = 0;
   int         ready_mode = 0;  // 0 always ready, 1 stalled, 2 random

   spi_recv #(.FIFO_DEPTH(Depth), .SYNC_STAGES(2)) dut (
      .axi_aclk   (axi_aclk),
      .axi_areset (axi_areset),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_cs     (spi_cs),
      .axis_wdata (axis_wdata),
      .axis_wvalid(axis_wvalid),
      .axis_wready(axis_wready),
      .axis_wlast (axis_wlast),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      axis_wready = 1'b1;
      forever begin
         @(posedge axi_aclk);
         #1;
         case (ready_mode)
            0:       axis_wready = 1'b1;
            1:       axis_wready = 1'b0;
            default: axis_wready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake and watches stall stability.
   logic       held = 1'b0, fe_prev = 1'b0;
   logic [8:0] held_val = '0;
   always @(negedge axi_aclk) begin
      if (axi_areset) begin
         held    = 1'b0;
         fe_prev = 1'b0;
      end else begin
         if (held) chk("stall_stable", {axis_wvalid, axis_wlast, axis_wdata}, {1'b1, held_val});
         if (axis_wvalid && axis_wready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {axis_wlast, axis_wdata}, 32'hdead);
            end else begin
               chk("beat", {axis_wlast, axis_wdata}, exp_q.pop_front());
               if (axis_wlast) chk("last_after_cs_fall", spi_cs, 0);
            end
         end
         held     = axis_wvalid && !axis_wready;
         held_val = {axis_wlast, axis_wdata};
         if (frame_err) begin
            chk("frame_err_width", fe_prev, 0);
            fe_cnt++;
         end
         fe_prev = frame_err;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge axi_aclk);
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      cycles(4);
      spi_clk = 1'b1;
      cycles(4);
      spi_clk = 1'b0;
   endtask

   // Expected stream: every complete byte in order, last on the final one; with the sink
   // stalled for the whole frame, anything beyond the FIFO capacity is lost.
   task automatic send_frame(input int partial, input bit stall);
      int occ;
      int n;
      occ = exp_q.size();
      n   = frame_q.size();
      for (int i = 0; i < n; i++) begin
         if (!stall || occ < Depth) begin
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, frame_q[i]});
            occ++;
         end else begin
            exp_ovf = 1'b1;
         end
      end
      spi_cs = 1'b1;
      cycles(6);
      for (int i = 0; i < n; i++)
         for (int b = 7; b >= 0; b--) spi_bit(frame_q[i][b]);
      for (int b = 0; b < partial; b++) spi_bit(1'($urandom_range(0, 1)));
      cycles(4);
      spi_cs = 1'b0;
      cycles(16);
      chk("frame_err_count", fe_cnt, (partial != 0) ? 1 : 0);
      fe_cnt = 0;
      chk("overflow", overflow, exp_ovf);
   endtask

   task automatic drain();
      int i;
      ready_mode = 0;
      for (i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge axi_aclk);
      chk("drain_empty", exp_q.size(), 0);
      exp_q.delete();
      cycles(4);
      chk("idle_valid", axis_wvalid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cycles(3);
      #1;
      chk("rst_valid", axis_wvalid, 0);
      chk("rst_data", axis_wdata, 0);
      chk("rst_last", axis_wlast, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_err", frame_err, 0);
      axi_areset = 1'b0;
      cycles(5);

      // Single byte
      frame_q = {8'hA5};
      send_frame(0, 0);
      drain();

      // Three bytes
      frame_q = {8'h01, 8'h80, 8'hFF};
      send_frame(0, 0);
      drain();

      // Back-pressure
      ready_mode = 1;
      frame_q = {8'h10, 8'h11, 8'h12, 8'h13};
      send_frame(0, 1);
      cycles(5);
      chk("bp_valid", axis_wvalid, 1);
      chk("bp_head", axis_wdata, 8'h10);
      drain();
      chk("bp_overflow", overflow, 0);

      // Overflow: 18 bytes into a 16-deep FIFO while stalled
      ready_mode = 1;
      frame_q = {};
      for (int i = 0; i < 18; i++) frame_q.push_back(8'(8'h40 + i));
      send_frame(0, 1);
      drain();
      chk("ovf_sticky", overflow, 1);

      // Partial frame
      frame_q = {8'h3C};
      send_frame(5, 0);
      drain();

      // Reset mid-frame with two bytes buffered
      ready_mode = 1;
      cycles(2);
      spi_cs = 1'b1;
      cycles(6);
      for (int b = 7; b >= 0; b--) spi_bit(b[0]);
      for (int b = 7; b >= 0; b--) spi_bit(~b[0]);
      for (int b = 7; b >= 0; b--) spi_bit(1'b1);
      for (int b = 0; b < 4; b++) spi_bit(1'b0);
      cycles(6);
      chk("pre_rst_valid", axis_wvalid, 1);
      @(posedge axi_aclk);
      #2 axi_areset = 1'b1;
      #1;
      chk("mid_rst_valid", axis_wvalid, 0);
      chk("mid_rst_overflow", overflow, 0);
      chk("mid_rst_data", axis_wdata, 0);
      spi_cs = 1'b0;
      spi_clk = 1'b0;
      cycles(5);
      axi_areset = 1'b0;
      exp_ovf = 1'b0;
      fe_cnt = 0;
      cycles(10);
      ready_mode = 0;
      frame_q = {8'h5A};
      send_frame(0, 0);
      drain();

      // Randomised frames with a random sink
      for (int f = 0; f < 10; f++) begin
         int nb;
         nb = $urandom_range(0, 5);
         frame_q = {};
         for (int i = 0; i < nb; i++) frame_q.push_back(8'($urandom_range(0, 255)));
         ready_mode = 2;
         send_frame($urandom_range(0, 7), 0);
         drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_recv.md
Name: spi_recv

Overview:
- SPI-slave receive path: oversamples spi_clk/spi_mosi/spi_cs in the axi_aclk domain, deserialises MOSI bytes MSB-first (SPI mode 0), and presents them as an AXI4-Stream master towards the CCU.
- Internal FIFO absorbs CCU back-pressure.
- axis_wlast marks the final complete byte of each chip-select frame.
- Counterpart of the MISO send path.

Parameters:
- FIFO_DEPTH, 16, entries in the internal {last,data} FIFO; power of two, at least 4.
- SYNC_STAGES, 2, flip-flop synchroniser depth on spi_clk, spi_mosi and spi_cs.

Ports:
- axi_aclk  input  1  system clock; the only clock, and every flop uses it.
- axi_areset  input  1  asynchronous, active-high reset.
- spi_clk  input  1  SPI clock from the master, asynchronous to axi_aclk; its frequency must not exceed axi_aclk/8.
- spi_mosi  input  1  serial data, sampled on the spi_clk rising edge.
- spi_cs  input  1  chip select, active-high (1 = slave selected).
- axis_wdata  output  8  received byte.
- axis_wvalid  output  1  AXI4-Stream valid.
- axis_wready  input  1  AXI4-Stream ready from the CCU.
- axis_wlast  output  1  set on the last complete byte of a frame.
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full; cleared only by reset.
- frame_err  output  1  one-cycle pulse when spi_cs deasserts with 1 to 7 bits pending.

Behaviour:
Reset and synchronisation
- Reset values: axis_wvalid=0, axis_wdata=0, axis_wlast=0, overflow=0, frame_err=0, FIFO empty, bit counter=0, hold register invalid, FSM in IDLE.
- Every synchroniser flop resets to 0.
- Edge detect uses the registered synchronised value of spi_clk. rise = sync=1 and prev=0.
- cs_fall = synchronised spi_cs goes 1→0. cs_rise = synchronised spi_cs goes 0→1.

FSM: IDLE
- Waits here while cs=0.
- On cs_rise: bit_cnt:=0, shift register :=0, go to ACTIVE.

FSM: ACTIVE
- On each rise: shift := {shift[6:0], mosi_sync}, bit_cnt := bit_cnt+1 (3-bit, wraps 7→0).
- On the rise that completes bit 8 (bit_cnt was 7), the byte is complete:
  - if hold is valid, push {last=0, hold_data} into the FIFO;
  - then hold := new byte, hold valid := 1.
- On cs_fall: go to END. This takes priority over a rise in the same cycle; that rise is ignored.

FSM: END (one cycle)
- If hold is valid: push {last=1, hold_data} and clear hold.
- If bit_cnt≠0: pulse frame_err for one cycle and discard the partial bits.
- Go to IDLE.
- A frame with zero complete bytes produces no stream output.

FIFO push
- A push when the FIFO is full drops that entry and sets overflow.
- If a push and a pop happen in the same cycle while the FIFO is full, the push is accepted.

Output stage
- Registered, first-word-fall-through.
- axis_wvalid=1 whenever the FIFO is non-empty.
- axis_wdata and axis_wlast are taken from the head entry.
- A pop occurs on the cycle where axis_wvalid && axis_wready.
- While axis_wvalid=1 and axis_wready=0, axis_wdata and axis_wlast must stay stable.
- axis_wvalid never depends combinationally on axis_wready.

Latency
- A complete byte enters the FIFO either on the cycle after the next byte completes, or on the END cycle.
- It reaches axis_wvalid one cycle after the push.
- Worst case from the completing edge of the last byte of a frame: SYNC_STAGES+1 cycles to the detected rise, plus the cs_fall detection, END and push cycles, plus 1 cycle to axis_wvalid.

Reset mid-operation
- Asserting axi_areset at any time immediately returns every state and output to its reset value.
- Partial bytes, the hold byte and FIFO contents are lost.
- After reset deassertion, a frame already in progress (cs=1) is ignored until cs_rise is observed.

Test Plan:
1. Single-byte frame: cs high, shift 0xA5 MSB-first, cs low, axis_wready=1 → exactly one beat: data 0xA5, last=1; frame_err=0.
2. Three-byte frame: shift 0x01,0x80,0xFF with axis_wready=1 → three beats in order; last is 0,0,1; the last beat appears only after cs_fall.
3. Back-pressure: axis_wready=0 while 4 bytes 0x10..0x13 are received, then axis_wready=1 → valid held with stable data 0x10 until ready; the 4 beats then drain in order; overflow=0.
4. Overflow: FIFO_DEPTH=16, axis_wready=0, one frame of 18 bytes → 16 entries buffered; 17th and 18th bytes dropped; overflow=1 and stays 1 after draining; the draining stream carries no last=1 beat.
5. Partial frame: 1 byte 0x3C then 5 bits, then cs low → one beat 0x3C with last=1; frame_err pulses exactly one cycle.
6. Reset mid-frame: assert axi_areset after 4 bits of a byte with 2 bytes already in the FIFO → axis_wvalid=0 immediately. After release, a new frame of 0x5A yields a single beat 0x5A with last=1.
